// File: rtl/fir_requant_if.sv
// fir_requant_if: accumulator input stream, requantized output stream and saturation diagnostics.
interface fir_requant_if #(
    parameter int IW   = 46,
    parameter int OW   = 24,
    parameter int CNTW = 16
);
    logic signed [IW-1:0] s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic signed [OW-1:0] m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tuser;
    logic [CNTW-1:0]      sat_count;
    logic                 sat_clear;
    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready, sat_clear,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, sat_count
    );
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready, sat_clear,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, sat_count
    );
endinterface

// File: rtl/fir_requant.sv
// fir_requant: rounds off SHIFT fractional bits of the MAC accumulator, saturates to OW bits
// and counts saturated output samples; two-stage pipeline with backpressure.
module fir_requant #(
    parameter int IW         = 46,
    parameter int OW         = 24,
    parameter int SHIFT      = 16,
    parameter int ROUND_MODE = 2,
    parameter int CNTW       = 16
) (
    input logic         clk,
    input logic         rst,
    fir_requant_if.slave bus
);
    localparam int HS = SHIFT > 0 ? SHIFT - 1 : 0;
    localparam logic signed [IW:0] HALF = SHIFT > 0 ? (IW+1)'(1) << HS : '0;
    localparam logic signed [IW:0] ONE  = 1;
    localparam logic signed [IW:0] MAXV = {{(IW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW:0] MINV = {{(IW-OW+2){1'b1}}, {(OW-1){1'b0}}};
    logic signed [IW:0] xe, lsb, r, r1, q;
    logic signed [OW-1:0] d, md;
    logic v1, mv, mu, adv1, adv2, sat_hi, sat_lo, hs_sat;
    logic [CNTW-1:0] cnt;
    always_comb begin
        adv2 = !mv || bus.m_axis_tready;
        adv1 = !v1 || adv2;
        xe   = {bus.s_axis_tdata[IW-1], bus.s_axis_tdata};
        lsb  = {{IW{1'b0}}, xe[SHIFT]};
        // convergent: bias is half-1, plus one more when the kept LSB is odd
        r = (SHIFT == 0 || ROUND_MODE == 0) ? xe :
            ROUND_MODE == 1 ? xe + HALF : xe + HALF - ONE + lsb;
        q      = r1 >>> SHIFT;
        sat_hi = q > MAXV;
        sat_lo = q < MINV;
        d = sat_hi ? {1'b0, {(OW-1){1'b1}}} : sat_lo ? {1'b1, {(OW-1){1'b0}}} : q[OW-1:0];
        hs_sat = mv && bus.m_axis_tready && mu;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            r1  <= '0;
            mv  <= 1'b0;
            md  <= '0;
            mu  <= 1'b0;
            cnt <= '0;
        end else begin
            if (adv1) begin
                v1 <= bus.s_axis_tvalid;
                r1 <= r;
            end
            if (adv2) begin
                mv <= v1;
                md <= d;
                mu <= sat_hi || sat_lo;
            end
            cnt <= bus.sat_clear ? CNTW'(hs_sat) : (hs_sat && cnt != '1) ? cnt + 1'b1 : cnt;
        end
    end
    assign bus.s_axis_tready = adv1;
    assign bus.m_axis_tvalid = mv;
    assign bus.m_axis_tdata  = md;
    assign bus.m_axis_tuser  = mu;
    assign bus.sat_count     = cnt;
endmodule

// File: tb/tb_fir_requant.sv
// tb_fir_requant: drives four requantizers (round modes 1/2/0 and a 2-bit counter variant)
// with shared stimulus and checks each against an arithmetic rounding/saturation model.
module tb_fir_requant;
    localparam int IW = 46;
    localparam int OW = 24;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    logic signed [IW-1:0] din = '0;
    logic vin = 0, rdy = 1, clr = 0;
    fir_requant_if #(.IW(IW), .OW(OW), .CNTW(16)) b0 ();
    fir_requant_if #(.IW(IW), .OW(OW), .CNTW(16)) b1 ();
    fir_requant_if #(.IW(IW), .OW(OW), .CNTW(16)) b2 ();
    fir_requant_if #(.IW(IW), .OW(OW), .CNTW(2))  b3 ();
    fir_requant #(.IW(IW), .OW(OW), .SHIFT(16), .ROUND_MODE(1), .CNTW(16)) u0 (.clk(clk), .rst(rst), .bus(b0));
    fir_requant #(.IW(IW), .OW(OW), .SHIFT(16), .ROUND_MODE(2), .CNTW(16)) u1 (.clk(clk), .rst(rst), .bus(b1));
    fir_requant #(.IW(IW), .OW(OW), .SHIFT(16), .ROUND_MODE(0), .CNTW(16)) u2 (.clk(clk), .rst(rst), .bus(b2));
    fir_requant #(.IW(IW), .OW(OW), .SHIFT(16), .ROUND_MODE(2), .CNTW(2))  u3 (.clk(clk), .rst(rst), .bus(b3));
    assign b0.s_axis_tdata = din; assign b0.s_axis_tvalid = vin; assign b0.m_axis_tready = rdy; assign b0.sat_clear = clr;
    assign b1.s_axis_tdata = din; assign b1.s_axis_tvalid = vin; assign b1.m_axis_tready = rdy; assign b1.sat_clear = clr;
    assign b2.s_axis_tdata = din; assign b2.s_axis_tvalid = vin; assign b2.m_axis_tready = rdy; assign b2.sat_clear = clr;
    assign b3.s_axis_tdata = din; assign b3.s_axis_tvalid = vin; assign b3.m_axis_tready = rdy; assign b3.sat_clear = clr;
    logic signed [OW-1:0] mdat[4];
    logic mval[4], muser[4], sready[4];
    logic [15:0] scnt[4];
    assign mdat[0] = b0.m_axis_tdata; assign mval[0] = b0.m_axis_tvalid; assign muser[0] = b0.m_axis_tuser;
    assign mdat[1] = b1.m_axis_tdata; assign mval[1] = b1.m_axis_tvalid; assign muser[1] = b1.m_axis_tuser;
    assign mdat[2] = b2.m_axis_tdata; assign mval[2] = b2.m_axis_tvalid; assign muser[2] = b2.m_axis_tuser;
    assign mdat[3] = b3.m_axis_tdata; assign mval[3] = b3.m_axis_tvalid; assign muser[3] = b3.m_axis_tuser;
    assign sready[0] = b0.s_axis_tready; assign sready[1] = b1.s_axis_tready;
    assign sready[2] = b2.s_axis_tready; assign sready[3] = b3.s_axis_tready;
    assign scnt[0] = b0.sat_count; assign scnt[1] = b1.sat_count;
    assign scnt[2] = b2.sat_count; assign scnt[3] = 16'(b3.sat_count);
    int mode[4] = '{1, 2, 0, 2};
    longint cmax[4] = '{65535, 65535, 65535, 3};
    int total = 0, bad = 0, cyc = 0, acc = 0;
    longint xs[$];
    int ts[$];
    int rd[4] = '{0, 0, 0, 0};
    longint cnt[4] = '{0, 0, 0, 0};
    bit stall[4] = '{0, 0, 0, 0};
    logic signed [OW-1:0] hd[4];
    logic hu[4];
    bit lat_chk = 0, rdy_one = 0;
    task automatic chk(string tag, int i, logic signed [63:0] obs, logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask
    // real-valued rounding of x / 2^16 expressed through floor and the discarded fraction
    function automatic longint rnd(int m, longint x);
        longint fl = x >>> 16;
        longint fr = x & 64'hFFFF;
        if (m == 1 && fr >= 32768) fl++;
        if (m == 2 && (fr > 32768 || (fr == 32768 && fl[0]))) fl++;
        return fl;
    endfunction
    task automatic tick();
        longint e;
        logic s;
        longint inc;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("sat_count", i, scnt[i], cnt[i]);
            if (stall[i]) begin
                chk("stall_valid", i, mval[i], 1);
                chk("stall_data", i, mdat[i], hd[i]);
                chk("stall_user", i, muser[i], hu[i]);
            end
            if (rdy_one) chk("in_ready", i, sready[i], 1);
        end
        if (rst) begin
            xs.delete(); ts.delete();
            for (int i = 0; i < 4; i++) begin rd[i] = 0; cnt[i] = 0; stall[i] = 0; end
        end else begin
            if (vin && sready[0]) begin xs.push_back(longint'(din)); ts.push_back(cyc); acc++; end
            for (int i = 0; i < 4; i++) begin
                inc = 0;
                if (mval[i] && rdy) begin
                    chk("no_extra", i, rd[i] < xs.size(), 1);
                    if (rd[i] < xs.size()) begin
                        e = rnd(mode[i], xs[rd[i]]);
                        s = e > 8388607 || e < -8388608;
                        e = s ? (e > 0 ? 8388607 : -8388608) : e;
                        chk("data", i, mdat[i], e);
                        chk("user", i, muser[i], s);
                        if (lat_chk) chk("latency", i, cyc - ts[rd[i]], 2);
                        inc = longint'(s);
                        rd[i]++;
                    end
                end
                cnt[i] = clr ? inc : (cnt[i] + inc > cmax[i] ? cmax[i] : cnt[i] + inc);
                stall[i] = mval[i] && !rdy;
                hd[i] = mdat[i];
                hu[i] = muser[i];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic send(longint v);
        din = v[IW-1:0];
        vin = 1;
        tick();
    endtask
    longint dl[8] = '{64'sh18000, 64'sh28000, -64'sh18000, 64'sh28001, 64'sh1FFFF, -64'sh1,
                      64'sh100_0000_0000, -64'sh100_0000_0000};
    initial begin
        longint v;
        int start;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_valid", i, mval[i], 0);
            chk("rst_data", i, mdat[i], 0);
            chk("rst_user", i, muser[i], 0);
            chk("rst_count", i, scnt[i], 0);
        end
        lat_chk = 1; rdy_one = 1;
        foreach (dl[k]) send(dl[k]);
        vin = 0;
        repeat (4) tick();
        chk("sat_two", 0, scnt[0], 2);
        clr = 1; tick(); clr = 0; tick();
        chk("sat_cleared", 0, scnt[0], 0);
        send(64'sh100_0000_0000);
        vin = 0; tick();
        clr = 1; tick(); clr = 0;
        chk("clr_with_sat", 0, scnt[0], 1);
        for (int k = 0; k < 5; k++) send(-64'sh200_0000_0000);
        vin = 0;
        repeat (4) tick();
        chk("cnt_sticks", 3, scnt[3], 3);
        lat_chk = 0; rdy_one = 0;
        start = acc;
        for (int g = 0; g < 2000 && acc < start + 100; g++) begin
            v = longint'({$urandom, $urandom}) >>> $urandom_range(44, 18);
            if ($urandom_range(3, 0) == 0) v = (v & ~64'hFFFF) | 64'h8000;
            din = v[IW-1:0];
            vin = 1'($urandom_range(1, 0));
            rdy = 1'($urandom_range(1, 0));
            clr = $urandom_range(15, 0) == 0;
            tick();
        end
        chk("rand_accepts", 0, acc - start, 100);
        clr = 0; vin = 0; rdy = 1;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) chk("drained", i, rd[i], xs.size());
        lat_chk = 1; rdy_one = 1;
        for (int k = 0; k < 20; k++) send(longint'({$urandom, $urandom}) >>> $urandom_range(40, 20));
        vin = 0;
        repeat (3) tick();
        lat_chk = 0; rdy_one = 0;
        rdy = 0;
        send(64'sh100_0000_0000);
        send(-64'sh3_0000);
        send(64'sh5_0000);
        chk("full_ready", 0, sready[0], 0);
        vin = 0;
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 4; i++) begin
            chk("midrst_valid", i, mval[i], 0);
            chk("midrst_count", i, scnt[i], 0);
        end
        rdy = 1; lat_chk = 1; rdy_one = 1;
        send(64'sh7_8000);
        vin = 0;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) chk("final_drain", i, rd[i], xs.size());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_requant.md
Name: fir_requant

Overview:
- Downstream stage of the FIR core. Takes the full-precision signed MAC accumulator stream and rounds away the COEFQ fractional bits. It then saturates the result to the output sample width and emits it as an AXI-Stream.
- Two-stage, fully pipelined with backpressure. It also flags and counts saturation events for coefficient-scaling diagnostics.

Parameters:
- IW, 46, input accumulator width (DW + COEFW + clog2(N)), signed
- OW, 24, output sample width, signed
- SHIFT, 16, fractional bits removed (equals COEFQ); 0 <= SHIFT < IW
- ROUND_MODE, 2, 0 = truncate (floor), 1 = round half up, 2 = convergent (round half to even)
- CNTW, 16, saturation counter width

Ports:
- clk  input  1  clock
- rst  input  1  reset
- s_axis_tdata  input  IW  signed accumulator sample
- s_axis_tvalid  input  1  input valid
- s_axis_tready  output  1  input ready
- m_axis_tdata  output  OW  signed requantized sample
- m_axis_tvalid  output  1  output valid
- m_axis_tready  input  1  output ready
- m_axis_tuser  output  1  sample was saturated (aligned with m_axis_tdata)
- sat_count  output  CNTW  number of saturated samples output since reset/clear
- sat_clear  input  1  single-cycle pulse, zeroes sat_count

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset:
  - all stage valids are 0, m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0, sat_count = 0.
  - rst mid-stream discards both in-flight samples; no partial output.
- Pipeline:
  - Stage 1 register holds the rounded value, IW+1 bits.
  - Stage 2 register (the output) holds the shifted, saturated value and the sat flag.
  - Latency 2 cycles from input handshake to m_axis_tvalid when unstalled. Throughput 1 sample/clk.
- Handshake:
  - adv2 = !m_axis_tvalid || m_axis_tready.
  - adv1 = !v1 || adv2.
  - s_axis_tready = adv1. This is combinational from m_axis_tready; accepted by the integration.
  - Stage 2 loads from stage 1 when adv2. m_axis_tvalid becomes v1 on that load.
  - Stage 1 loads the input when adv1; v1 becomes s_axis_tvalid.
  - m_axis_tdata and tuser stay stable while tvalid && !tready.
- Rounding (stage 1), x sign-extended to IW+1:
  - mode 0: r = x.
  - mode 1: r = x + 2^(SHIFT-1).
  - mode 2: r = x + 2^(SHIFT-1) - 1 + x[SHIFT].
  - If SHIFT = 0, r = x in all modes.
  - The IW+1 width guarantees no overflow.
- Shift/saturate (stage 2):
  - q = r >>> SHIFT (arithmetic).
  - If q > 2^(OW-1)-1: output 2^(OW-1)-1 and tuser = 1.
  - If q < -2^(OW-1): output -2^(OW-1) and tuser = 1.
  - Otherwise output q[OW-1:0] and tuser = 0.
- sat_count:
  - Increments by 1 on each output handshake (m_axis_tvalid && m_axis_tready) with tuser = 1.
  - Saturates at 2^CNTW - 1; it does not wrap.
- sat_clear:
  - Clears the counter to 0.
  - If sat_clear coincides with a counted handshake, sat_count becomes 1.

Test Plan:
- ROUND_MODE=1, SHIFT=16: inputs 0x18000, 0x28000, -0x18000 -> outputs 2, 3, -1; tuser = 0; first output valid 2 cycles after first accept.
- ROUND_MODE=2: inputs 0x18000, 0x28000, -0x18000, 0x28001 -> outputs 2, 2, -2, 3.
- ROUND_MODE=0: inputs 0x1FFFF, -0x1 -> outputs 1, -1.
- Saturation: inputs 2^40, -2^40 -> 8388607 and -8388608, tuser = 1; sat_count = 2. Pulse sat_clear -> 0. Drive sat_clear during a saturated handshake -> 1. CNTW=2 with 5 saturated samples -> sat_count stays at 3.
- Backpressure: stream 100 random samples with tvalid and tready each randomly toggled at 50%. Required response:
  - output sequence matches the reference model exactly;
  - no drops or duplicates;
  - output is stable while stalled;
  - with tready held at 1, throughput is 1/clk.
- Reset mid-operation: assert rst for 1 cycle with both stages full and m_axis_tready = 0 -> next cycle m_axis_tvalid = 0 and sat_count = 0. The next accepted sample appears 2 cycles later.
